// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF evaluation sequencer: state encoding
// and the default geometry reused by the PUF top level.
package puf_pkg;

    localparam int unsigned PUF_C_LENGTH      = 16;
    localparam int unsigned PUF_SETTLE_CYCLES = 4;
    localparam int unsigned PUF_HOLD_CYCLES   = 4;
    localparam int unsigned PUF_NUM_EVALS     = 7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_FIRE   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Host-side challenge/response handshake of the PUF evaluation sequencer.
interface puf_eval_ctrl_if
    import puf_pkg::*;
#(
    parameter int unsigned C_LENGTH = PUF_C_LENGTH
) ();

    logic                ichallenge_valid;
    logic                ochallenge_ready;
    logic [C_LENGTH-1:0] ichallenge_data;
    logic                oresponse_valid;
    logic                iresponse_ready;
    logic                oresponse;
    logic                ostable;

    modport master (
        output ichallenge_valid,
        output ichallenge_data,
        output iresponse_ready,
        input  ochallenge_ready,
        input  oresponse_valid,
        input  oresponse,
        input  ostable
    );

    modport slave (
        input  ichallenge_valid,
        input  ichallenge_data,
        input  iresponse_ready,
        output ochallenge_ready,
        output oresponse_valid,
        output oresponse,
        output ostable
    );

endinterface

// File: rtl/puf_sync.sv
// Two-flop synchronizer bringing the asynchronous arbiter output into iclk.
module puf_sync (
    input  logic iclk,
    input  logic irst,
    input  logic iasync,
    output logic osync
);

    logic sync_p0_q;
    logic sync_p1_q;

    always_ff @(posedge iclk) begin
        if (irst) begin
            sync_p0_q <= 1'b0;
            sync_p1_q <= 1'b0;
        end else begin
            sync_p0_q <= iasync;
            sync_p1_q <= sync_p0_q;
        end
    end

    assign osync = sync_p1_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF sequencer: applies a challenge, launches it NUM_EVALS times with
// settle gaps, and returns the majority vote plus an all-samples-agree flag.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int unsigned C_LENGTH      = PUF_C_LENGTH,
    parameter int unsigned SETTLE_CYCLES = PUF_SETTLE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = PUF_HOLD_CYCLES,
    parameter int unsigned NUM_EVALS     = PUF_NUM_EVALS
) (
    input  logic                iclk,
    input  logic                irst,
    puf_eval_ctrl_if.slave      host,
    output logic [C_LENGTH-1:0] opuf_challenge,
    output logic                opuf_pulse,
    input  logic                ipuf_response,
    output logic                obusy
);

    localparam int unsigned PH_W = $clog2(max_u(SETTLE_CYCLES, HOLD_CYCLES));
    localparam int unsigned EV_W = $clog2(NUM_EVALS + 1);

    localparam logic [PH_W-1:0] PH_SETTLE = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_HOLD   = PH_W'(HOLD_CYCLES - 1);
    localparam logic [EV_W-1:0] LAST_EVAL = EV_W'(NUM_EVALS - 1);
    localparam logic [EV_W-1:0] ALL_ONES  = EV_W'(NUM_EVALS);
    localparam logic [EV_W-1:0] HALF      = EV_W'(NUM_EVALS / 2);

    logic [1:0]          state_q,  state_d;
    logic [PH_W-1:0]     phase_q,  phase_d;
    logic [EV_W-1:0]     eval_q,   eval_d;
    logic [EV_W-1:0]     ones_q,   ones_d;
    logic [C_LENGTH-1:0] chal_q,   chal_d;
    logic                pulse_q,  pulse_d;
    logic                resp_q,   resp_d;
    logic                stable_q, stable_d;
    logic                sample;

    puf_sync u_sync (
        .iclk   (iclk),
        .irst   (irst),
        .iasync (ipuf_response),
        .osync  (sample)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        eval_d   = eval_q;
        ones_d   = ones_q;
        chal_d   = chal_q;
        pulse_d  = 1'b0;
        resp_d   = resp_q;
        stable_d = stable_q;

        case (state_q)
            ST_IDLE: begin
                if (host.ichallenge_valid) begin
                    chal_d  = host.ichallenge_data;
                    eval_d  = '0;
                    ones_d  = '0;
                    phase_d = PH_SETTLE;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (phase_q == '0) begin
                    phase_d = PH_HOLD;
                    pulse_d = 1'b1;
                    state_d = ST_FIRE;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            ST_FIRE: begin
                if (phase_q == '0) begin
                    // The synchronized sample is only trusted on the last high cycle.
                    ones_d = ones_q + EV_W'(sample);
                    eval_d = eval_q + EV_W'(1);
                    if (eval_q == LAST_EVAL) begin
                        resp_d   = (ones_d > HALF);
                        stable_d = (ones_d == '0) || (ones_d == ALL_ONES);
                        state_d  = ST_DONE;
                    end else begin
                        phase_d = PH_SETTLE;
                        state_d = ST_SETTLE;
                    end
                end else begin
                    phase_d = phase_q - PH_W'(1);
                    pulse_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (host.iresponse_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            eval_q   <= '0;
            ones_q   <= '0;
            chal_q   <= '0;
            pulse_q  <= 1'b0;
            resp_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            eval_q   <= eval_d;
            ones_q   <= ones_d;
            chal_q   <= chal_d;
            pulse_q  <= pulse_d;
            resp_q   <= resp_d;
            stable_q <= stable_d;
        end
    end

    assign host.ochallenge_ready = (state_q == ST_IDLE);
    assign host.oresponse_valid  = (state_q == ST_DONE);
    assign host.oresponse        = resp_q;
    assign host.ostable          = stable_q;
    assign opuf_challenge        = chal_q;
    assign opuf_pulse            = pulse_q;
    assign obusy                 = (state_q != ST_IDLE);

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed and randomized bench for puf_eval_ctrl with a behavioural PUF model.
module tb_puf_eval_ctrl;

    localparam int S  = 4;
    localparam int H  = 4;
    localparam int N  = 7;
    localparam int S2 = 1;
    localparam int H2 = 3;
    localparam int N2 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    puf_eval_ctrl_if #(.C_LENGTH(16)) h ();
    puf_eval_ctrl_if #(.C_LENGTH(16)) h2 ();

    logic [15:0] puf_chal, puf_chal2;
    logic        puf_pulse, puf_pulse2;
    logic        puf_resp  = 1'b0;
    logic        puf_resp2 = 1'b0;
    logic        busy, busy2;

    puf_eval_ctrl #(.C_LENGTH(16), .SETTLE_CYCLES(S), .HOLD_CYCLES(H), .NUM_EVALS(N)) dut (
        .iclk           (clk),
        .irst           (rst),
        .host           (h),
        .opuf_challenge (puf_chal),
        .opuf_pulse     (puf_pulse),
        .ipuf_response  (puf_resp),
        .obusy          (busy)
    );

    puf_eval_ctrl #(.C_LENGTH(16), .SETTLE_CYCLES(S2), .HOLD_CYCLES(H2), .NUM_EVALS(N2)) dut2 (
        .iclk           (clk),
        .irst           (rst),
        .host           (h2),
        .opuf_challenge (puf_chal2),
        .opuf_pulse     (puf_pulse2),
        .ipuf_response  (puf_resp2),
        .obusy          (busy2)
    );

    // PUF model: eval k (counted from each launch) answers with bit k of pat.
    int          evn  = 0;
    logic [31:0] pat  = '0;
    logic        pat2 = 1'b0;
    always @(posedge puf_pulse) begin
        puf_resp = pat[evn[4:0]];
        evn++;
    end
    always @(posedge puf_pulse2) begin
        puf_resp2 = pat2;
    end

    // Continuous monitor: settle gap, pulse width, challenge stability while busy.
    int          low_run     = 0;
    int          high_run    = 0;
    logic        prev_pulse  = 1'b0;
    logic        prev_busy   = 1'b0;
    logic [15:0] prev_chal   = '0;
    bit          mon_inhibit = 1'b0;
    always @(negedge clk) begin
        if (puf_pulse === 1'b1 && prev_pulse === 1'b0) begin
            tests++;
            assert (low_run >= S) else begin
                fails++;
                $error("FAIL pulse_gap: observed %0d low cycles, expected >= %0d", low_run, S);
            end
            high_run = 1;
        end else if (puf_pulse === 1'b1) begin
            high_run++;
        end else if (prev_pulse === 1'b1) begin
            if (!mon_inhibit) begin
                tests++;
                assert (high_run == H) else begin
                    fails++;
                    $error("FAIL pulse_width: observed %0d expected %0d", high_run, H);
                end
            end
            low_run = 1;
        end else begin
            low_run++;
        end
        if (busy === 1'b1 && prev_busy === 1'b1) begin
            tests++;
            assert (puf_chal === prev_chal) else begin
                fails++;
                $error("FAIL chal_stable: observed 0x%0h expected 0x%0h", puf_chal, prev_chal);
            end
        end
        prev_pulse = puf_pulse;
        prev_busy  = busy;
        prev_chal  = puf_chal;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Majority vote and agreement over the first n evaluations, {response, stable}.
    function automatic logic [1:0] model(input logic [31:0] p, input int n);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += int'(p[i]);
        return {(2 * ones > n), (ones == 0 || ones == n)};
    endfunction

    // Called at a negedge; handshake happens at the following posedge.
    task automatic send(input logic [15:0] c);
        chk("ready_before_send", {31'd0, h.ochallenge_ready}, 32'd1);
        h.ichallenge_valid = 1'b1;
        h.ichallenge_data  = c;
        @(posedge clk);
        #1;
        h.ichallenge_valid = 1'b0;
        chk("chal_loaded", {16'd0, puf_chal}, {16'd0, c});
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (h.oresponse_valid !== 1'b1 && cyc < 500);
    endtask

    task automatic run_txn(input logic [15:0] c, input logic [31:0] p, input string tag);
        int          cyc;
        logic [1:0]  e;
        e   = model(p, N);
        evn = 0;
        pat = p;
        send(c);
        wait_result(cyc);
        chk({tag, "_latency"}, cyc, N * (S + H) + 1);
        chk({tag, "_resp"},    {31'd0, h.oresponse}, {31'd0, e[1]});
        chk({tag, "_stable"},  {31'd0, h.ostable},   {31'd0, e[0]});
        chk({tag, "_pulses"},  evn, N);
        chk({tag, "_chal"},    {16'd0, puf_chal}, {16'd0, c});
    endtask

    task automatic release_result();
        h.iresponse_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        h.iresponse_ready = 1'b0;
        chk("idle_ready", {31'd0, h.ochallenge_ready}, 32'd1);
        chk("idle_valid", {31'd0, h.oresponse_valid},  32'd0);
        chk("idle_busy",  {31'd0, busy},               32'd0);
    endtask

    initial begin
        logic [15:0] c;
        logic [31:0] p;
        int          cyc;
        int          cnt;

        h.ichallenge_valid  = 1'b0;
        h.ichallenge_data   = '0;
        h.iresponse_ready   = 1'b0;
        h2.ichallenge_valid = 1'b0;
        h2.ichallenge_data  = '0;
        h2.iresponse_ready  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pulse",  {31'd0, puf_pulse},          32'd0);
        chk("rst_chal",   {16'd0, puf_chal},           32'd0);
        chk("rst_resp",   {31'd0, h.oresponse},        32'd0);
        chk("rst_stable", {31'd0, h.ostable},          32'd0);
        chk("rst_valid",  {31'd0, h.oresponse_valid},  32'd0);
        chk("rst_busy",   {31'd0, busy},               32'd0);
        chk("rst_ready",  {31'd0, h.ochallenge_ready}, 32'd1);
        rst = 1'b0;

        run_txn(16'hA5A5, 32'h7F, "all_ones");
        release_result();
        run_txn(16'h3C3C, 32'h55, "four_ones");
        release_result();
        run_txn(16'h0F0F, 32'h2A, "three_ones");
        release_result();

        run_txn(16'hBEEF, 32'h7F, "hold");
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                h.ichallenge_valid = 1'b1;
                h.ichallenge_data  = 16'h1234;
            end
            if (i == 7) h.ichallenge_valid = 1'b0;
            chk("hold_valid",  {31'd0, h.oresponse_valid},  32'd1);
            chk("hold_ready",  {31'd0, h.ochallenge_ready}, 32'd0);
            chk("hold_resp",   {31'd0, h.oresponse},        32'd1);
            chk("hold_stable", {31'd0, h.ostable},          32'd1);
            chk("hold_chal",   {16'd0, puf_chal},           32'hBEEF);
            @(negedge clk);
        end
        release_result();
        run_txn(16'hC0DE, 32'h7F, "after_hold");
        release_result();

        evn = 0;
        pat = 32'h7F;
        send(16'h5A5A);
        cnt = 0;
        while (!(evn == 3 && puf_pulse === 1'b1) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_reach_fire3", {31'd0, cnt < 200}, 32'd1);
        mon_inhibit = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_pulse", {31'd0, puf_pulse},          32'd0);
        chk("midrst_busy",  {31'd0, busy},               32'd0);
        chk("midrst_valid", {31'd0, h.oresponse_valid},  32'd0);
        chk("midrst_ready", {31'd0, h.ochallenge_ready}, 32'd1);
        chk("midrst_chal",  {16'd0, puf_chal},           32'd0);
        chk("midrst_resp",  {31'd0, h.oresponse},        32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (h.oresponse_valid === 1'b1) cnt++;
        end
        chk("midrst_no_valid", cnt, 0);
        mon_inhibit = 1'b0;
        run_txn(16'h7777, 32'h2A, "post_rst");
        release_result();

        for (int k = 0; k < 5; k++) begin
            c = 16'($urandom);
            p = 32'($urandom_range(0, 127));
            run_txn(c, p, "rand");
            release_result();
        end

        for (int k = 0; k < 2; k++) begin
            pat2 = (k == 0) ? 1'($urandom_range(0, 1)) : ~pat2;
            c = 16'($urandom);
            chk("sw_ready", {31'd0, h2.ochallenge_ready}, 32'd1);
            h2.ichallenge_valid = 1'b1;
            h2.ichallenge_data  = c;
            @(posedge clk);
            #1;
            h2.ichallenge_valid = 1'b0;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (h2.oresponse_valid !== 1'b1 && cyc < 100);
            chk("sw_latency", cyc, N2 * (S2 + H2) + 1);
            chk("sw_resp",   {31'd0, h2.oresponse}, {31'd0, pat2});
            chk("sw_stable", {31'd0, h2.ostable},   32'd1);
            chk("sw_chal",   {16'd0, puf_chal2},    {16'd0, c});
            h2.iresponse_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            h2.iresponse_ready = 1'b0;
            chk("sw_idle", {31'd0, busy2}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
